// File: rtl/spec_pkg.sv
// Shared types and sizing helpers for the spectrogram write controller.
// Optional statistics counters are enabled by defining SPEC_WR_CTRL_STATS_EN.
package spec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SKIP  = 2'd2,
        DROP  = 2'd3
    } state_t;

    // Counter width for a power-of-two count, never narrower than one bit.
    function automatic int unsigned count_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned bins_kept_of(input int unsigned fft_size);
        return fft_size / 2;
    endfunction

    localparam int unsigned DEF_FFT_SIZE      = 256;
    localparam int unsigned DEF_FFTS_PER_BANK = 32;
    localparam int unsigned BINS_KEPT         = bins_kept_of(DEF_FFT_SIZE);
    localparam int unsigned BIN_W             = count_w(DEF_FFT_SIZE);
    localparam int unsigned ROW_W             = count_w(DEF_FFTS_PER_BANK);

endpackage

// File: rtl/spec_bank_owner.sv
// Ping-pong bank ownership: per-bank full flags and the active-bank pointer.
module spec_bank_owner #(
    parameter int unsigned NO_BANKS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_full,
    input  logic [NO_BANKS-1:0] bank_release,
    output logic                active,
    output logic [NO_BANKS-1:0] bank_full
);

    logic [NO_BANKS-1:0] active_mask;

    always_comb begin
        active_mask = NO_BANKS'(1) << active;
    end

    // Release is applied first so a simultaneous set on the same bank wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            active    <= 1'b0;
        end else begin
            bank_full <= (bank_full & ~bank_release) | (set_full ? active_mask : '0);
            if (set_full) begin
                active <= ~active;
            end
        end
    end

endmodule

// File: rtl/spec_wr_ctrl.sv
// Writes the lower half of each FFT frame into ping-pong spectrogram banks.
// Define SPEC_WR_CTRL_STATS_EN to build the saturating drop/error counters.
module spec_wr_ctrl
    import spec_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned FFT_SIZE      = 256,
    parameter int unsigned FFTS_PER_BANK = 32,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NO_BANKS      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic                     s_last,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic [NO_BANKS-1:0]      bank_release,
    output logic                     wr_en,
    output logic [NO_BANKS-1:0]      bank_select,
    output logic [ADDRESS_WIDTH-1:0] wr_address,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic [NO_BANKS-1:0]      bank_full,
    output logic                     frame_drop,
    output logic                     frame_err,
    output logic [15:0]              drop_count,
    output logic [15:0]              err_count
);

    localparam int unsigned BW   = count_w(FFT_SIZE);
    localparam int unsigned RW   = count_w(FFTS_PER_BANK);
    localparam int unsigned KEPT = bins_kept_of(FFT_SIZE);
    localparam logic [BW-1:0] BIN_LAST = BW'(FFT_SIZE - 1);
    localparam logic [BW-1:0] BIN_HALF = BW'(KEPT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FFTS_PER_BANK - 1);

    state_t        state, state_nx;
    logic [BW-1:0] bin, bin_nx, cur_bin;
    logic [RW-1:0] row, row_nx;
    logic          active;
    logic          set_full;
    logic          writing, dropping, frame_end;
    logic          do_write, drop_end, err_end;

    always_comb begin
        state_nx  = state;
        bin_nx    = bin;
        row_nx    = row;
        set_full  = 1'b0;
        do_write  = 1'b0;
        drop_end  = 1'b0;
        err_end   = 1'b0;
        frame_end = 1'b0;
        // The first sample seen in IDLE is always bin 0 of a new frame.
        cur_bin   = (state == IDLE) ? '0 : bin;
        writing   = ((state == IDLE) && !bank_full[active]) || (state == WRITE);
        dropping  = ((state == IDLE) &&  bank_full[active]) || (state == DROP);
        if (s_valid) begin
            frame_end = s_last || (cur_bin == BIN_LAST);
            bin_nx    = frame_end ? '0 : cur_bin + 1'b1;
            do_write  = writing;
            if (frame_end) begin
                state_nx = IDLE;
            end else if (dropping) begin
                state_nx = DROP;
            end else if (writing) begin
                state_nx = (cur_bin == BIN_HALF) ? SKIP : WRITE;
            end else begin
                state_nx = SKIP;
            end
            if (frame_end && dropping) begin
                drop_end = 1'b1;
            end else if (frame_end && (cur_bin == BIN_LAST)) begin
                if (row == ROW_LAST) begin
                    set_full = 1'b1;
                    row_nx   = '0;
                end else begin
                    row_nx   = row + 1'b1;
                end
            end else if (frame_end) begin
                err_end = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bin         <= '0;
            row         <= '0;
            wr_en       <= 1'b0;
            bank_select <= '0;
            wr_address  <= '0;
            wr_data     <= '0;
            frame_drop  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            bin         <= bin_nx;
            row         <= row_nx;
            wr_en       <= do_write;
            bank_select <= do_write ? (NO_BANKS'(1) << active) : '0;
            frame_drop  <= drop_end;
            frame_err   <= err_end;
            if (do_write) begin
                wr_address <= ADDRESS_WIDTH'(row) * ADDRESS_WIDTH'(KEPT) + ADDRESS_WIDTH'(cur_bin);
                wr_data    <= s_data;
            end
        end
    end

    spec_bank_owner #(
        .NO_BANKS (NO_BANKS)
    ) u_bank_owner (
        .clk          (clk),
        .rst          (rst),
        .set_full     (set_full),
        .bank_release (bank_release),
        .active       (active),
        .bank_full    (bank_full)
    );

`ifdef SPEC_WR_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            if (drop_end && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (err_end && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`else
    assign drop_count = '0;
    assign err_count  = '0;
`endif

endmodule

// File: tb/tb_spec_wr_ctrl.sv
// Scoreboard bench for spec_wr_ctrl: a frame-level model predicts writes and pulses.
module tb_spec_wr_ctrl;

    localparam int AW   = 12;
    localparam int FS   = 256;
    localparam int FPB  = 2;
    localparam int DW   = 16;
    localparam int KEPT = FS / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_last;
    logic [DW-1:0] s_data;
    logic [1:0]    bank_release;
    logic          wr_en;
    logic [1:0]    bank_select;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] wr_data;
    logic [1:0]    bank_full;
    logic          frame_drop;
    logic          frame_err;
    logic [15:0]   drop_count;
    logic [15:0]   err_count;

    spec_wr_ctrl #(
        .ADDRESS_WIDTH (AW),
        .FFT_SIZE      (FS),
        .FFTS_PER_BANK (FPB),
        .DATA_WIDTH    (DW),
        .NO_BANKS      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_data       (s_data),
        .bank_release (bank_release),
        .wr_en        (wr_en),
        .bank_select  (bank_select),
        .wr_address   (wr_address),
        .wr_data      (wr_data),
        .bank_full    (bank_full),
        .frame_drop   (frame_drop),
        .frame_err    (frame_err),
        .drop_count   (drop_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            stamp;
    } wr_t;

    wr_t exp_q[$];
    int  ev_q[$];        // 1 = short-frame error, 2 = dropped frame
    int  checks = 0;
    int  passed = 0;

    int         m_bank;
    int         m_row;
    logic [1:0] m_full;
    int         m_drops;
    int         m_errs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: every write and every pulse consumes the oldest prediction.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'(bank_select), 32'(wr_address)}, 64'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_bank_select", 64'(bank_select), 64'(e.sel));
                check("wr_address", 64'(wr_address), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
                check("wr_latency", 64'(cyc), 64'(e.stamp + 1));
            end
        end
        if (frame_err) begin
            if (ev_q.size() == 0) check("unexpected_frame_err", 64'd1, 64'd0);
            else check("frame_err_event", 64'd1, 64'(ev_q.pop_front()));
        end
        if (frame_drop) begin
            if (ev_q.size() == 0) check("unexpected_frame_drop", 64'd2, 64'd0);
            else check("frame_drop_event", 64'd2, 64'(ev_q.pop_front()));
        end
    end

    task automatic model_reset();
        m_bank  = 0;
        m_row   = 0;
        m_full  = 2'b00;
        m_drops = 0;
        m_errs  = 0;
    endtask

    task automatic drive(input bit v, input bit last, input logic [DW-1:0] d, input logic [1:0] rel);
        @(posedge clk);
        #1;
        s_valid      = v;
        s_last       = last;
        s_data       = d;
        bank_release = rel;
    endtask

    task automatic check_status(input string tag);
        int exp_drops;
        int exp_errs;
`ifdef SPEC_WR_CTRL_STATS_EN
        exp_drops = (m_drops > 65535) ? 65535 : m_drops;
        exp_errs  = (m_errs  > 65535) ? 65535 : m_errs;
`else
        exp_drops = 0;
        exp_errs  = 0;
`endif
        check({tag, "_bank_full"}, 64'(bank_full), 64'(m_full));
        check({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drops));
        check({tag, "_err_count"}, 64'(err_count), 64'(exp_errs));
    endtask

    // One frame of len samples; rel_mask is pulsed on sample rel_idx.
    task automatic send_frame(input int len, input int rel_idx, input logic [1:0] rel_mask,
                              input bit gaps, input bit b2b, input string tag);
        bit            dropped;
        logic [DW-1:0] d;
        dropped = m_full[m_bank];
        for (int i = 0; i < len; i++) begin
            if (gaps && ($urandom_range(0, 7) == 0)) drive(1'b0, 1'b0, DW'($urandom), 2'b00);
            d = DW'($urandom);
            drive(1'b1, i == len - 1, d, (i == rel_idx) ? rel_mask : 2'b00);
            if (!dropped && i < KEPT) begin
                exp_q.push_back('{sel: (m_bank == 1) ? 2'b10 : 2'b01,
                                  addr: AW'(m_row * KEPT + i), data: d, stamp: cyc});
            end
        end
        if (rel_idx >= 0 && rel_idx < len) m_full = m_full & ~rel_mask;
        if (dropped) begin
            ev_q.push_back(2);
            m_drops++;
        end else if (len == FS) begin
            m_row++;
            if (m_row == FPB) begin
                m_full[m_bank] = 1'b1;
                m_bank         = 1 - m_bank;
                m_row          = 0;
            end
        end else begin
            ev_q.push_back(1);
            m_errs++;
        end
        if (!b2b) begin
            drive(1'b0, 1'b0, '0, 2'b00);
            @(negedge clk);
            check_status(tag);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_datapath", {wr_en, bank_select, wr_address, wr_data, frame_drop, frame_err},
              64'h0);
        check("reset_status", {bank_full, drop_count, err_count}, 64'h0);
        model_reset();
    endtask

    initial begin
        int len;
        int rel_idx;
        logic [1:0] rel_mask;
        rst          = 1'b1;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        s_data       = '0;
        bank_release = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Fill bank 0 then bank 1, drop the fifth frame while releasing bank 0.
        send_frame(FS, -1, 2'b00, 1'b0, 1'b0, "frame1");
        send_frame(FS, -1, 2'b00, 1'b0, 1'b0, "frame2");
        send_frame(FS, -1, 2'b00, 1'b1, 1'b0, "frame3");
        send_frame(FS, -1, 2'b00, 1'b0, 1'b0, "frame4");
        send_frame(FS, 100, 2'b01, 1'b0, 1'b0, "frame5_drop");
        send_frame(FS, -1, 2'b00, 1'b0, 1'b0, "frame6_after_release");

        // Short frame then a full frame overwriting the same row.
        do_reset();
        send_frame(100, -1, 2'b00, 1'b0, 1'b0, "short");
        send_frame(FS, -1, 2'b00, 1'b0, 1'b0, "rewrite_row0");

        // Abandon a frame at bin 50 with reset.
        for (int i = 0; i < 50; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            drive(1'b1, 1'b0, d, 2'b00);
            exp_q.push_back('{sel: (m_bank == 1) ? 2'b10 : 2'b01,
                              addr: AW'(m_row * KEPT + i), data: d, stamp: cyc});
        end
        do_reset();
        send_frame(FS, -1, 2'b00, 1'b0, 1'b0, "post_reset");

        // Randomized traffic: short frames, gaps, back-to-back frames, releases.
        for (int f = 0; f < 30; f++) begin
            len      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FS - 1) : FS;
            rel_idx  = -1;
            rel_mask = 2'b00;
            if ($urandom_range(0, 2) == 0) begin
                rel_idx  = $urandom_range(0, len - 1);
                rel_mask = 2'($urandom_range(1, 3));
            end
            send_frame(len, rel_idx, rel_mask, 1'($urandom_range(0, 1)),
                       (f != 29) && ($urandom_range(0, 3) == 0), "random");
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("writes_outstanding", 64'(exp_q.size()), 64'd0);
        check("events_outstanding", 64'(ev_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
